// File: rtl/uart_pkg.sv
// Shared constants for the word-oriented UART transmitter.
// State encoding and frame geometry live here so the bench and RTL agree.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_txiv.sv
// 32-bit word UART transmitter: four 8N1 frames per word, LSB byte first.
// Enable freezes everything; reset aborts any word and idles the line high.
module uart_txiv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        en,
    input  logic        has_next,
    output logic        Tx_Serial_Output,
    output logic        clk_out,
    output logic        finish_Int,
    output logic        W_READY
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_CNT  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shreg;
    logic          fin_r;
    logic          wrap;

    assign wrap       = (baud == LAST_CNT);
    assign clk_out    = en && (state != IDLE) && wrap;
    assign finish_Int = fin_r && en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            baud             <= '0;
            bit_idx          <= '0;
            byte_idx         <= '0;
            shreg            <= '0;
            fin_r            <= 1'b0;
            Tx_Serial_Output <= 1'b1;
            W_READY          <= 1'b1;
        end else if (!en) begin
            fin_r <= 1'b0;
        end else begin
            fin_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (has_next) begin
                        shreg            <= data;
                        W_READY          <= 1'b0;
                        state            <= START;
                        Tx_Serial_Output <= 1'b0;
                        baud             <= '0;
                        bit_idx          <= '0;
                        byte_idx         <= '0;
                    end
                end
                START: begin
                    if (wrap) begin
                        baud             <= '0;
                        state            <= DATA;
                        bit_idx          <= '0;
                        Tx_Serial_Output <= shreg[0];
                        shreg            <= shreg >> 1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        baud <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state            <= STOP;
                            Tx_Serial_Output <= 1'b1;
                        end else begin
                            bit_idx          <= bit_idx + 1'b1;
                            Tx_Serial_Output <= shreg[0];
                            shreg            <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        baud <= '0;
                        // Shift register already holds the next byte in [7:0]
                        if (byte_idx == LAST_BYTE) begin
                            state   <= IDLE;
                            fin_r   <= 1'b1;
                            W_READY <= 1'b1;
                        end else begin
                            byte_idx         <= byte_idx + 1'b1;
                            state            <= START;
                            Tx_Serial_Output <= 1'b0;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txiv.sv
// Scoreboard bench for uart_txiv: a line receiver decodes frames and
// checks them, plus finish timing and baud tick counts, against queued words.
module tb_uart_txiv;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        en;
    logic        has_next;
    logic        Tx_Serial_Output;
    logic        clk_out;
    logic        finish_Int;
    logic        W_READY;

    int tests;
    int failed;
    int cyc;

    logic [7:0] byte_q[$];
    int         fin_q[$];

    uart_txiv #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .en(en),
        .has_next(has_next),
        .Tx_Serial_Output(Tx_Serial_Output),
        .clk_out(clk_out),
        .finish_Int(finish_Int),
        .W_READY(W_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: UART receiver sampling mid-bit, counting only enabled cycles
    initial begin
        bit          rx_on;
        int          rx_n;
        int          nclk;
        int          exp_fin;
        logic [9:0]  rx_bits;
        logic [7:0]  exp_b;
        rx_on = 0;
        rx_n = 0;
        nclk = 0;
        rx_bits = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rx_on = 0;
                nclk = 0;
            end else begin
                if (clk_out) nclk++;
                if (finish_Int) begin
                    if (fin_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL finish_unexpected: got pulse expected none (cycle %0d)", cyc);
                    end else begin
                        exp_fin = fin_q.pop_front();
                        check("finish_time", cyc, exp_fin);
                        check("clk_out_count", nclk, 40);
                        check("ready_with_finish", W_READY, 1);
                    end
                    nclk = 0;
                end
                if (!rx_on && Tx_Serial_Output == 1'b0) begin
                    rx_on = 1;
                    rx_n = 0;
                    rx_bits = '0;
                end
                if (rx_on && en) begin
                    if (rx_n % CPB == CPB / 2) rx_bits[rx_n / CPB] = Tx_Serial_Output;
                    rx_n++;
                    if (rx_n == 10 * CPB) begin
                        rx_on = 0;
                        check("start_bit", rx_bits[0], 0);
                        check("stop_bit", rx_bits[9], 1);
                        if (byte_q.size() == 0) begin
                            tests++;
                            failed++;
                            $display("FAIL byte_unexpected: got %0h expected none", rx_bits[8:1]);
                        end else begin
                            exp_b = byte_q.pop_front();
                            check("rx_byte", rx_bits[8:1], exp_b);
                        end
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input int fin_at);
        for (int i = 0; i < 4; i++) byte_q.push_back(w[8*i +: 8]);
        fin_q.push_back(fin_at);
    endtask

    // Caller sits just after a rising edge with the DUT idle
    task automatic send(input logic [31:0] w, input bit hold, input int extra, output int acc);
        check("ready_before", W_READY, 1);
        data = w;
        has_next = 1'b1;
        acc = cyc + 1;
        push_word(w, acc + 40 * CPB + extra);
        @(posedge clk);
        #1;
        check("ready_accept", W_READY, 0);
        if (!hold) has_next = 1'b0;
        data = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((byte_q.size() != 0 || fin_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            tests++;
            failed++;
            $display("FAIL timeout: got %0d pending expected 0", byte_q.size() + fin_q.size());
            byte_q.delete();
            fin_q.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int acc;
        int gap;
        logic lvl;
        tests = 0;
        failed = 0;
        rst = 1'b0;
        en = 1'b1;
        has_next = 1'b0;
        data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", Tx_Serial_Output, 1);
        check("rst_ready", W_READY, 1);
        check("rst_finish", finish_Int, 0);
        check("rst_clk_out", clk_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single word immediately after reset release
        send(32'hA5C30F81, 1'b0, 0, acc);
        wait_done();

        // Back-to-back via held request
        send(32'h00000000, 1'b1, 0, acc);
        data = 32'hFFFFFFFF;
        push_word(32'hFFFFFFFF, acc + 80 * CPB + 1);
        wait_cyc(acc + 40 * CPB + 1);
        check("second_accept", W_READY, 0);
        has_next = 1'b0;
        data = $urandom;
        wait_done();

        // Freeze during bit 3 of byte 1
        @(posedge clk);
        #1;
        send($urandom, 1'b0, 10, acc);
        wait_cyc(acc + 14 * CPB + 1);
        en = 1'b0;
        lvl = Tx_Serial_Output;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("freeze_line", Tx_Serial_Output, lvl);
            check("freeze_clk_out", clk_out, 0);
        end
        en = 1'b1;
        wait_done();

        // Start request while disabled is ignored
        @(posedge clk);
        #1;
        en = 1'b0;
        has_next = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("dis_ready", W_READY, 1);
            check("dis_line", Tx_Serial_Output, 1);
        end
        has_next = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of byte 2
        send(32'hCAFEBABE, 1'b0, 0, acc);
        wait_cyc(acc + 20 * CPB + 6);
        rst = 1'b0;
        byte_q.delete();
        fin_q.delete();
        #1;
        check("midrst_tx", Tx_Serial_Output, 1);
        check("midrst_ready", W_READY, 1);
        check("midrst_finish", finish_Int, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send(32'h12345678, 1'b0, 0, acc);
        wait_done();

        // Random words with random idle gaps
        for (int k = 0; k < 6; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 1'b0, 0, acc);
            wait_done();
        end

        repeat (5) @(posedge clk);
        #1;
        check("queues_drained", byte_q.size() + fin_q.size(), 0);
        check("final_ready", W_READY, 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_txiv.md
UART_TXIV -- requirements
Module: uart_txiv

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416: system clocks per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port data, input, 32 bits: word to transmit, sampled at start of a word.
REQ-005 SHALL have port en, input, 1 bit: enable; when low, all state, counters and outputs freeze.
REQ-006 SHALL have port has_next, input, 1 bit: level request meaning "a word is pending".
REQ-007 SHALL have port Tx_Serial_Output, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port clk_out, output, 1 bit: baud tick.
REQ-009 SHALL have port finish_Int, output, 1 bit: word-complete interrupt pulse.
REQ-010 SHALL have port W_READY, output, 1 bit: high when idle and able to accept a word.

Function
REQ-011 SHALL transmit each 32-bit word as four 8N1 frames: byte 0 (data[7:0]) first, byte 3 last; bits LSB first.
- Frame: 1 start bit (0), 8 data bits, 1 stop bit (1).
REQ-012 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL accept a word on the clock edge where state is IDLE, en=1 and has_next=1.
- On that edge: latch data into an internal shift register, clear W_READY, enter START.
- Tx_Serial_Output goes low on the following cycle.
REQ-014 SHALL hold each bit for exactly CLKS_PER_BIT clocks, counted by a baud counter that runs 0..CLKS_PER_BIT-1.
REQ-015 SHALL, in DATA, advance the bit index 0..7; after bit 7, enter STOP.
REQ-016 SHALL, at the end of STOP, do the following:
- Byte index < 3: increment byte index and enter START directly, with no idle gap.
- Byte index = 3: enter IDLE.
REQ-017 SHALL make one word occupy exactly 40*CLKS_PER_BIT clocks from the first start-bit cycle to the end of the last stop bit.
REQ-018 SHALL, on the cycle IDLE is re-entered, pulse finish_Int high for exactly one clock and set W_READY high.
REQ-019 SHALL pulse clk_out high for one clock each time the baud counter wraps while not IDLE; clk_out SHALL be 0 in IDLE.
REQ-020 SHALL ignore changes on data and has_next while busy; the latched word is not corrupted.
REQ-021 SHALL treat has_next as level-sensitive: if has_next is still 1 in the cycle W_READY returns high, the next word starts on that edge (back-to-back, one idle cycle).
REQ-022 SHALL, when en=0, freeze the FSM, counters and Tx_Serial_Output at their current values; clk_out and finish_Int SHALL be 0 while en=0.
REQ-023 SHALL, when en=0 coincides with a start condition, not accept the word.
REQ-024 SHALL drive Tx_Serial_Output from a register (glitch-free).

Reset
REQ-025 SHALL, when rst=0, immediately and asynchronously force the following:
- state IDLE;
- Tx_Serial_Output=1, W_READY=1, finish_Int=0, clk_out=0;
- baud counter, bit index, byte index and shift register all 0.
REQ-026 SHALL, if reset occurs mid-frame, abort the word with no finish_Int and leave the line high.
REQ-027 SHALL, after reset deassertion, accept a word on the first qualifying edge.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE, START, DATA, STOP) and the frame constants (8 data bits, 4 bytes per word) in a shared package uart_pkg.
REQ-029 SHALL be implemented as a single module with no sub-modules; the baud counter is inline.
- A natural optional split is a sub-module uart_baud_gen producing the tick.
REQ-030 SHALL size the baud counter as $clog2(CLKS_PER_BIT).

Verification
REQ-031 SHALL cover single word: CLKS_PER_BIT=4, data=0xA5C30F81, has_next pulsed for 1 clock.
- Line carries frames 0x81, 0x0F, 0xC3, 0xA5, each as 0, LSB-first bits, 1.
- finish_Int pulses once, 160 clocks after the first start bit.
REQ-032 SHALL cover ready handshake: W_READY falls on the accept edge and rises with finish_Int; clk_out pulses 40 times per word.
REQ-033 SHALL cover held request: has_next held 1 with data=0x00000000 then 0xFFFFFFFF.
- Two words go back-to-back.
- Second word's data bits are all 1.
- Two finish_Int pulses.
REQ-034 SHALL cover enable freeze: en=0 for 10 clocks during bit 3 of byte 1.
- Line level holds.
- The word completes 10 clocks later than nominal (170 clocks).
REQ-035 SHALL cover reset mid-word: rst=0 during byte 2.
- Line goes 1 immediately, W_READY=1, no finish_Int.
- A new word 0x12345678 then transmits correctly.
REQ-036 SHALL cover data stability: data is changed during transmission and the transmitted bytes still match the latched word.
